// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide unit with annul, early termination
// and divide-by-zero reporting. Result is {hi, lo}: {product} or {remainder, quotient}.
module muldiv_iter #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic neg);
    cond_neg_w = neg ? (~x + WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic neg);
    cond_neg_2w = neg ? (~x + (2*WIDTH)'(1)) : x;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag1_q, mag1_d;
  logic [WIDTH-1:0]   mag2_q, mag2_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_dvd_q, neg_dvd_d;
  logic               dbz_q, dbz_d;

  logic               sgn1, sgn2;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   dvd_orig;

  always_comb begin
    // Signed ops (op_i[0] == 0) work on magnitudes; signs are restored on entering DONE.
    sgn1     = ~op_i[0] & opdata1_i[WIDTH-1];
    sgn2     = ~op_i[0] & opdata2_i[WIDTH-1];
    mul_sum  = acc_q + (mag2_q[0] ? mcand_q : '0);
    // Restoring step: trial-subtract the divisor from the shifted upper half (WIDTH+1 bits).
    trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag2_q};
    div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    dvd_orig = cond_neg_w(mag1_q, neg_dvd_q);

    state_d   = state_q;
    cnt_d     = cnt_q;
    mag1_d    = mag1_q;
    mag2_d    = mag2_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    result_d  = result_q;
    neg_res_d = neg_res_q;
    neg_dvd_d = neg_dvd_q;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          mag1_d    = cond_neg_w(opdata1_i, sgn1);
          mag2_d    = cond_neg_w(opdata2_i, sgn2);
          mcand_d   = {{WIDTH{1'b0}}, mag1_d};
          acc_d     = op_i[1] ? {{WIDTH{1'b0}}, mag1_d} : '0;
          neg_res_d = sgn1 ^ sgn2;
          neg_dvd_d = sgn1;
          dbz_d     = 1'b0;
          cnt_d     = '0;
          state_d   = op_i[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (EARLY_TERM && cnt_q == '0 && (mag1_q == '0 || mag2_q == '0)) begin
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          acc_d   = mul_sum;
          mcand_d = mcand_q << 1;
          mag2_d  = mag2_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = cond_neg_2w(mul_sum, neg_res_q);
            state_d  = S_DONE;
          end
        end
      end
      S_DIV: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0 && mag2_q == '0) begin
          result_d = {dvd_orig, {WIDTH{1'b1}}};
          dbz_d    = 1'b1;
          state_d  = S_DONE;
        end else if (EARLY_TERM && cnt_q == '0 && mag1_q < mag2_q) begin
          result_d = {dvd_orig, {WIDTH{1'b0}}};
          state_d  = S_DONE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_d = {cond_neg_w(div_next[2*WIDTH-1:WIDTH], neg_dvd_q),
                        cond_neg_w(div_next[WIDTH-1:0], neg_res_q)};
            state_d  = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mag1_q    <= '0;
      mag2_q    <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag1_q    <= mag1_d;
      mag2_q    <= mag2_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      neg_res_q <= neg_res_d;
      neg_dvd_q <= neg_dvd_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign ready_o       = (state_q == S_DONE);
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the EX stage, successor to the fixed 32-bit mul/div pair. It handles signed and unsigned multiply and divide through one start/ready handshake, and adds annul, early termination and divide-by-zero reporting. EX asserts stall while busy_o is high and the result is not yet ready. The 2*WIDTH result feeds the HI/LO write path as {hi, lo}.

Parameters:
WIDTH, 32, operand width; must be even and at least 4.
EARLY_TERM, 1, enables the zero-operand and small-dividend shortcuts (1 = on).

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
start_i  in  1  request; sampled only in IDLE.
op_i  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
opdata1_i  in  WIDTH  multiplicand or dividend.
opdata2_i  in  WIDTH  multiplier or divisor.
annul_i  in  1  abort the current or requested operation.
busy_o  out  1  high when state != IDLE.
ready_o  out  1  one-cycle pulse; result_o is valid during it.
result_o  out  2*WIDTH  multiply: {product_hi, product_lo}; divide: {remainder, quotient}.
div_by_zero_o  out  1  set with ready_o when a divide had opdata2 == 0; held until the next accept.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state = IDLE; counter and datapath registers = 0.
  - busy_o = 0, ready_o = 0, result_o = 0, div_by_zero_o = 0.
- States: IDLE, MUL, DIV, DONE.
- Accept:
  - Occurs in IDLE at an edge with start_i=1 and annul_i=0.
  - Latches op, |opdata1|, |opdata2| (magnitude only for signed ops), sign of the result and sign of the dividend.
  - Clears div_by_zero_o.
  - Next state is MUL or DIV; counter = 0.
- MUL: radix-2 shift-add, one bit per edge, WIDTH edges. Then DONE.
- DIV: restoring division over a 2*WIDTH partial remainder, one quotient bit per edge, WIDTH edges. Then DONE.
- Sign correction is applied on the edge entering DONE:
  - Product is negated (two's complement, 2*WIDTH bits) if the operand signs differ.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Latency: if the accept edge is E0, ready_o is high in the cycle after edge E0+WIDTH. For WIDTH=32 that is sampled at E0+33.
- Shortcuts, each entering DONE at E0+1 (ready_o sampled at E0+2):
  - Divide by zero (always active): result_o = {opdata1, all ones}, div_by_zero_o = 1.
  - EARLY_TERM=1, multiply with either operand 0: result_o = 0.
  - EARLY_TERM=1, divide with |dividend| < |divisor|: quotient = 0, remainder = opdata1 unchanged.
- DONE:
  - Lasts exactly one cycle with ready_o=1, then IDLE.
  - start_i is ignored in DONE.
  - result_o and div_by_zero_o hold their values until the next accept.
- Annul:
  - annul_i=1 in MUL, DIV or DONE: next edge goes to IDLE, ready_o is 0, result_o is left unchanged.
  - annul_i together with start_i in IDLE: no accept.
- Overflow: signed div of -2^(WIDTH-1) by -1 gives quotient 0x80..0 (wraps) and remainder 0. No flag.
- Operand inputs need not be held stable after the accept edge.
- Reset asserted mid-operation: immediate return to reset values, no ready_o pulse.

Test Plan:
1. multu 0xFFFFFFFF × 0xFFFFFFFF (WIDTH=32) -> ready_o at edge E0+33, result_o = 0xFFFFFFFE_00000001, busy_o high for 33 cycles.
2. mult -3 × 5 -> result_o = 0xFFFFFFFF_FFFFFFF1. Also mult 0 × 0x1234 with EARLY_TERM=1 -> result 0, ready at E0+2.
3. div -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
4. divu 5 / 0 -> ready at E0+2, div_by_zero_o = 1, result_o = 0x00000005_FFFFFFFF. Also divu 3 / 10 -> quotient 0, remainder 3, ready at E0+2.
5. Start divu 100 / 7, annul_i pulsed at E0+10 -> state IDLE at E0+11, no ready_o, result_o keeps its prior value. A new divu 100 / 7 then yields quotient 14, remainder 2.
6. resetn pulled low asynchronously mid-MUL (between edges) -> busy_o, ready_o and result_o go to 0 immediately. After release, start_i is accepted normally. Repeat with WIDTH=8: multu 0xFF × 0xFF = 0xFE01, ready at E0+9.
